speck_decrypt_core: RTL and testbench
=====================================

Name: speck_decrypt_core

Overview:
- Iterative SPECK128/128 decryption engine: 64-bit words, 32 rounds, alpha=8, beta=3.
- It is the inverse path of the existing round_encrypt/key_schedule encryption chain. It takes a ciphertext block and the master key, and returns the plaintext.
- Round keys are generated on the fly. The block runs the key schedule forward to k31, then inverts it one step per decryption round, so no round-key RAM is needed.
- It sits beside the encryption datapath under the cipher top-level and uses the same start/finished handshake.

Parameters:
- WORD_W, 64: SPECK word width. Only 64 is supported; the parameter exists for package consistency.
- NR_ROUNDS, 32: number of rounds. It also sets the round counter width, clog2(NR_ROUNDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- signal_start  in  1  request pulse/level. Sampled only in IDLE or DONE.
- key  in  128  master key: [127:64]=k0, [63:0]=l0.
- ciphertext  in  128  block: [127:64]=x, [63:0]=y.
- plaintext  out  128  decrypted block. Valid while finished=1.
- busy  out  1  high in KEY_EXPAND and DECRYPT.
- finished  out  1  high in DONE; held until the next accepted start or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE; plaintext=0, busy=0, finished=0; internal x, y, k, l and counter cleared.
- States: IDLE, KEY_EXPAND, DECRYPT, DONE.
- IDLE/DONE with signal_start=1 at edge N:
  - latch k=key[127:64], l=key[63:0], x=ciphertext[127:64], y=ciphertext[63:0];
  - cnt=0; finished<=0; state<=KEY_EXPAND.
- KEY_EXPAND, one step per cycle, i=cnt (0..30):
  - l <= (k + ROR(l,8)) ^ i;
  - k <= ROL(k,3) ^ new l.
  - After i=30 (edge N+31): k=k31, l=l31, cnt<=31, state<=DECRYPT.
- DECRYPT, r=cnt (31 down to 0), one round per cycle:
  - y' = ROR(x ^ y, 3);
  - x' = ROL((x ^ k) - y', 8).
  - Same cycle, when r>0, inverse schedule step with i=r-1:
    - k' = ROR(k ^ l, 3);
    - l' = ROL((l ^ i) - k', 8).
  - When r=0 (edge N+63): plaintext <= {x',y'}, finished<=1, state<=DONE.
- Latency: 63 clock edges from the accepting edge to finished=1.
- Arithmetic: all add/sub modulo 2^64 (carry/borrow discarded). i is zero-extended to 64 bits.
- signal_start while busy: ignored. Inputs are not re-sampled; key/ciphertext may change freely after the accepting edge.
- signal_start held high: restarts on every entry to DONE, giving back-to-back operations. finished pulses for one cycle per result in that case.
- DONE with no start: plaintext and finished held.
- rst mid-operation: immediate abort to IDLE with all outputs 0. No partial result is exposed.

Optional Feature:
- Macro: SPECK_KEY_CACHE_EN.
- With the macro defined:
  - The block stores the last master key plus its k31/l31 and a valid bit; valid is cleared by reset.
  - On an accepted start where key equals the cached key and valid=1, the block loads k31/l31 directly and goes straight to DECRYPT. Latency is 32 edges.
  - On a cache miss it runs the normal path and refreshes the cache at the end of KEY_EXPAND.
- Without the macro: no cache registers. Latency is always 63 edges.

Decomposition:
- Package speck_pkg holds:
  - WORD_W, NR_ROUNDS, ALPHA=8, BETA=3;
  - the state encoding localparams;
  - rotate functions ror/rol.
- One natural sub-module: speck_inv_round, combinational. Inputs x, y, k, l, i; outputs x', y', k', l'. It is reusable by a future unrolled decryptor.

Test Plan:
- Standard vector: key=128'h0706050403020100_0f0e0d0c0b0a0908, ciphertext=128'ha65d985179783265_7860fedf5c570d18 -> plaintext=128'h6c61766975716520_7469206564616d20. finished rises exactly 63 edges after start; busy high for those 63 cycles.
- Round trip: encrypt 64 random key/plaintext pairs through the existing round_encrypt/key_schedule chain (or a C model), feed the results here -> original plaintext recovered every time.
- Start during busy: pulse signal_start at cycle 10 with a different ciphertext -> ignored, result still equals the first vector, latency unchanged.
- Reset mid-op: assert rst at cycle 20 of a decrypt -> plaintext=0, finished=0, busy=0 immediately. A new start then produces the correct standard-vector result.
- Back-to-back: signal_start held high with two different ciphertexts under the same key -> two correct results, each finished for one cycle.
- Key cache (SPECK_KEY_CACHE_EN): repeat the standard vector twice -> second result correct with latency 32. Change the key -> latency 63 and correct result.

Source files
------------

// File: rtl/speck_pkg.sv
// speck_pkg: shared SPECK128/128 constants, state encoding and rotate helpers.
package speck_pkg;

    localparam int WORD_W    = 64;
    localparam int NR_ROUNDS = 32;
    localparam int ALPHA     = 8;
    localparam int BETA      = 3;
    localparam int CNT_W     = $clog2(NR_ROUNDS);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        KEY_EXPAND = 2'd1,
        DECRYPT    = 2'd2,
        DONE       = 2'd3
    } state_t;

    function automatic word_t ror(input word_t v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    function automatic word_t rol(input word_t v, input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/speck_inv_round.sv
// speck_inv_round: one combinational SPECK decryption round plus the matching
// inverse key-schedule step.
module speck_inv_round
    import speck_pkg::*;
(
    input  word_t x,
    input  word_t y,
    input  word_t k,
    input  word_t l,
    input  word_t i,
    output word_t x_next,
    output word_t y_next,
    output word_t k_next,
    output word_t l_next
);

    assign y_next = ror(x ^ y, BETA);
    assign x_next = rol((x ^ k) - y_next, ALPHA);
    assign k_next = ror(k ^ l, BETA);
    assign l_next = rol((l ^ i) - k_next, ALPHA);

endmodule

// File: rtl/speck_decrypt_core.sv
// speck_decrypt_core: iterative SPECK128/128 decryptor, forward key expansion to
// k31 then on-the-fly inversion. Optional key cache: SPECK_KEY_CACHE_EN.
module speck_decrypt_core
    import speck_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         finished
);

    state_t           state, state_next;
    word_t            x, y, k, l;
    logic [CNT_W-1:0] cnt;
    logic             accept, hit, last_expand;
    word_t            k_fwd, l_fwd, load_k, load_l;
    word_t            x_inv, y_inv, k_inv, l_inv;

    assign accept      = signal_start && (state == IDLE || state == DONE);
    assign last_expand = cnt == CNT_W'(NR_ROUNDS - 2);
    assign l_fwd       = (k + ror(l, ALPHA)) ^ word_t'(cnt);
    assign k_fwd       = rol(k, BETA) ^ l_fwd;

    speck_inv_round u_round (
        .x      (x),
        .y      (y),
        .k      (k),
        .l      (l),
        .i      (word_t'(CNT_W'(cnt - CNT_W'(1)))),
        .x_next (x_inv),
        .y_next (y_inv),
        .k_next (k_inv),
        .l_next (l_inv)
    );

`ifdef SPECK_KEY_CACHE_EN
    // Cache key is captured at a miss so later key changes cannot corrupt it.
    logic [127:0] cache_key;
    word_t        cache_k, cache_l;
    logic         cache_valid;

    assign hit    = cache_valid && key == cache_key;
    assign load_k = hit ? cache_k : key[127:64];
    assign load_l = hit ? cache_l : key[63:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key   <= '0;
            cache_k     <= '0;
            cache_l     <= '0;
            cache_valid <= 1'b0;
        end else if (accept && !hit) begin
            cache_key   <= key;
            cache_valid <= 1'b0;
        end else if (state == KEY_EXPAND && last_expand) begin
            cache_k     <= k_fwd;
            cache_l     <= l_fwd;
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit    = 1'b0;
    assign load_k = key[127:64];
    assign load_l = key[63:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (accept) state_next = hit ? DECRYPT : KEY_EXPAND;
            KEY_EXPAND: if (last_expand) state_next = DECRYPT;
            DECRYPT:    if (cnt == '0) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = state == KEY_EXPAND || state == DECRYPT;
        finished = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            k         <= '0;
            l         <= '0;
            cnt       <= '0;
            plaintext <= '0;
        end else if (accept) begin
            x   <= ciphertext[127:64];
            y   <= ciphertext[63:0];
            k   <= load_k;
            l   <= load_l;
            cnt <= hit ? CNT_W'(NR_ROUNDS - 1) : '0;
        end else if (state == KEY_EXPAND) begin
            k   <= k_fwd;
            l   <= l_fwd;
            cnt <= cnt + CNT_W'(1);
        end else if (state == DECRYPT) begin
            x   <= x_inv;
            y   <= y_inv;
            k   <= k_inv;
            l   <= l_inv;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) plaintext <= {x_inv, y_inv};
        end
    end

endmodule

// File: tb/tb_speck_decrypt_core.sv
// tb_speck_decrypt_core: round-trip vectors from a reference encryptor plus
// hand-written busy/reset/back-to-back/cache sequences.
module tb_speck_decrypt_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         signal_start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] ciphertext = '0;
    logic [127:0] plaintext;
    logic         busy, finished;

    int errors = 0;
    int checks = 0;

    logic [127:0] m_key = '0;
    bit           m_valid = 1'b0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[65];

    localparam logic [127:0] STD_KEY = 128'h0706050403020100_0f0e0d0c0b0a0908;
    localparam logic [127:0] STD_CT  = 128'ha65d985179783265_7860fedf5c570d18;
    localparam logic [127:0] STD_PT  = 128'h6c61766975716520_7469206564616d20;

    speck_decrypt_core dut (
        .clk          (clk),
        .rst          (rst),
        .signal_start (signal_start),
        .key          (key),
        .ciphertext   (ciphertext),
        .plaintext    (plaintext),
        .busy         (busy),
        .finished     (finished)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    // Reference encryptor: full round-key table, then 32 forward rounds.
    function automatic logic [127:0] encrypt(input logic [127:0] k128, input logic [127:0] pt);
        logic [63:0] rk[32];
        logic [63:0] a, b, x, y;
        a = k128[127:64];
        b = k128[63:0];
        for (int i = 0; i < 32; i++) begin
            rk[i] = a;
            b = (a + rr(b, 8)) ^ 64'(i);
            a = rl(a, 3) ^ b;
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 32; i++) begin
            x = (rr(x, 8) + y) ^ rk[i];
            y = rl(y, 3) ^ x;
        end
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [127:0] k128, input logic [127:0] ct);
        signal_start = 1'b1;
        key = k128;
        ciphertext = ct;
        @(posedge clk);
        #1;
        signal_start = 1'b0;
        key = ~k128;
        ciphertext = ~ct;
    endtask

    task automatic wait_done(input int pulse_at, input logic [127:0] alt, output int lat, output int bc);
        bit done;
        done = 1'b0;
        lat = 0;
        bc = int'(busy);
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (finished) done = 1'b1;
            else begin
                bc += int'(busy);
                if (lat == pulse_at) begin
                    signal_start = 1'b1;
                    ciphertext = alt;
                end else if (lat == pulse_at + 1) signal_start = 1'b0;
            end
        end
    endtask

    task automatic check_result(input string name, input logic [127:0] k128,
                                input logic [127:0] exp_pt, input int lat, input int bc);
        int exp_lat;
        exp_lat = 63;
`ifdef SPECK_KEY_CACHE_EN
        if (m_valid && m_key == k128) exp_lat = 32;
`endif
        chk({name, " latency"}, 128'(lat), 128'(exp_lat));
        chk({name, " busy_cycles"}, 128'(bc), 128'(exp_lat));
        chk({name, " plaintext"}, plaintext, exp_pt);
        chk({name, " busy_in_done"}, 128'(busy), 128'(0));
        m_key = k128;
        m_valid = 1'b1;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat, bc;
        start_op(v.key, v.ct);
        wait_done(-1, '0, lat, bc);
        check_result(name, v.key, v.pt, lat, bc);
    endtask

    initial begin
        int lat, bc;
        logic [127:0] pt_b, ct_b;
        vecs[0] = '{STD_KEY, STD_CT, STD_PT};
        for (int i = 1; i < 65; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = encrypt(vecs[i].key, vecs[i].pt);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset plaintext", plaintext, '0);
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset finished", 128'(finished), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle finished", 128'(finished), 128'(0));

        for (int i = 0; i < 65; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        start_op(STD_KEY, STD_CT);
        wait_done(10, vecs[1].ct, lat, bc);
        check_result("start_during_busy", STD_KEY, STD_PT, lat, bc);

        start_op(vecs[5].key, vecs[5].ct);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset plaintext", plaintext, '0);
        chk("midreset busy", 128'(busy), 128'(0));
        chk("midreset finished", 128'(finished), 128'(0));
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec("after_reset", vecs[0]);

        run_vec("cache_repeat", vecs[0]);
        run_vec("cache_newkey", vecs[2]);

        pt_b = {$urandom, $urandom, $urandom, $urandom};
        ct_b = encrypt(vecs[3].key, pt_b);
        signal_start = 1'b1;
        key = vecs[3].key;
        ciphertext = vecs[3].ct;
        @(posedge clk);
        #1;
        ciphertext = ct_b;
        wait_done(-1, '0, lat, bc);
        check_result("b2b_first", vecs[3].key, vecs[3].pt, lat, bc);
        @(posedge clk);
        #1;
        chk("b2b finished_pulse", 128'(finished), 128'(0));
        chk("b2b busy_restart", 128'(busy), 128'(1));
        wait_done(-1, '0, lat, bc);
        signal_start = 1'b0;
        check_result("b2b_second", vecs[3].key, pt_b, lat, bc);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold finished", 128'(finished), 128'(1));
        chk("done_hold plaintext", plaintext, pt_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
